axis_pkt_source: RTL and testbench
==================================

# axis_pkt_source

AXI-Stream packet transmitter that produces bursts of fixed-length packets with incrementing data and TLAST framing, honouring downstream backpressure. It is the master-side counterpart of the sync FIFO's slave input. Its primary use is driving stimulus into the FIFO and other AXI-Stream sinks in the blackbox cores, both in the lab and on-chip for loopback tests.

## Interface
- P_DATA_WIDTH, 16, width of M_AXIS_T_DATA and cfg_seed
- P_LEN_WIDTH, 8, width of cfg_len (beats per packet)
- P_CNT_WIDTH, 8, width of cfg_num_pkts and pkt_sent
- P_GAP_WIDTH, 4, width of cfg_gap (idle cycles between packets)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  burst request, sampled only while busy=0
- cfg_len  in  P_LEN_WIDTH  beats per packet; 0 is invalid
- cfg_num_pkts  in  P_CNT_WIDTH  packets per burst; 0 is invalid
- cfg_gap  in  P_GAP_WIDTH  idle cycles inserted between packets
- cfg_seed  in  P_DATA_WIDTH  data value of the first beat
- busy  out  1  high from the cycle after an accepted start until the burst completes
- done  out  1  one-cycle pulse at burst completion
- pkt_sent  out  P_CNT_WIDTH  packets completed in the current or last burst
- M_AXIS_T_VALID  out  1  beat valid
- M_AXIS_T_READY  in  1  sink ready
- M_AXIS_T_DATA  out  P_DATA_WIDTH  beat data
- M_AXIS_T_LAST  out  1  last beat of packet

## Operation
- FSM states: IDLE, SEND, GAP.
- **IDLE**
  - start=1 with cfg_len≠0 and cfg_num_pkts≠0 is an accepted start.
  - On an accepted start: latch all cfg_* inputs, load data ← cfg_seed, clear the beat counter and pkt_sent, go to SEND.
  - start with a zero length or zero packet count is ignored; the FSM stays in IDLE.
- **SEND**
  - VALID=1.
  - LAST=1 when beat index = latched len−1.
  - A handshake is any cycle with VALID & READY.
  - Per handshake: data ← data+1 (modulo 2^P_DATA_WIDTH) and beat index ← beat index+1.
  - Data is continuous across packets within a burst; it is not reloaded per packet.
- **On a handshake with LAST=1:**
  - pkt_sent ← pkt_sent+1 and beat index ← 0.
  - If this was the final packet: go to IDLE and pulse done.
  - Else if gap=0: stay in SEND; the next packet starts the following cycle, back-to-back.
  - Else: go to GAP.
- **GAP**
  - VALID=0 for exactly the latched gap cycles, then return to SEND.
- **AXI-Stream rules**
  - VALID never depends combinationally on READY.
  - Once VALID=1, VALID, DATA and LAST hold stable until the handshake.
  - All outputs are registered.
- **Configuration changes:** cfg_* changes while busy=1 have no effect.
- **start while busy:** ignored.
- **pkt_sent:** holds its value after done until the next accepted start.

## Timing
- **Reset values:** VALID=0, LAST=0, DATA=0, busy=0, done=0, pkt_sent=0; state IDLE.
- **Start latency:** an accepted start in cycle T gives busy=1 and VALID=1 with DATA=seed in cycle T+1.
- **Throughput:** one beat per cycle while READY=1.
- **Packet spacing:** with gap=g>0, the LAST handshake is followed by exactly g cycles of VALID=0.
- **Completion:** final handshake in cycle H gives VALID=0, LAST=0, busy=0, done=1 in cycle H+1. done lasts one cycle, and a start in H+1 is accepted.
- **Reset mid-burst:** rst takes effect the next cycle regardless of handshake state. VALID drops even mid-stall, all outputs return to reset values, and no done pulse is produced.
- **Single-beat packets:** len=1 means every beat has LAST=1.

## Test plan
- **Basic packet:** seed=0x0010, len=4, num=1, gap=0, READY=1, start at T → beats 0x0010..0x0013 in T+1..T+4, LAST only at T+4, done=1 and busy=0 at T+5, pkt_sent=1.
- **Backpressure:** len=3, READY pattern 0,1,0,0,1,1 → DATA/LAST stable across every stall, exactly 3 handshakes carrying seed, seed+1, seed+2, VALID never deasserts before a handshake.
- **Gaps and continuity:** seed=0, len=2, num=3, gap=2, READY=1 → VALID pattern 1,1,0,0,1,1,0,0,1,1, DATA 0..5, LAST on beats 1, 3 and 5, done after the sixth beat, pkt_sent=3.
- **Wrap and single-beat packets:** seed=0xFFFE, len=1, num=3, gap=0 → DATA 0xFFFE, 0xFFFF, 0x0000 on consecutive cycles, each with LAST=1.
- **Ignored starts:**
  - start with len=0, then with num=0 → VALID stays 0, busy stays 0.
  - start pulsed mid-burst → burst unchanged, no restart.
- **Reset mid-packet:** VALID=1, READY=0, rst=1 for one cycle → next cycle VALID=0, busy=0, pkt_sent=0, no done pulse. A fresh start then produces DATA=seed one cycle later.

Source files
------------

// File: rtl/axis_pkt_source.sv
// axis_pkt_source: AXI-Stream burst generator of fixed-length packets with incrementing data and gaps
module axis_pkt_source #(
  parameter int P_DATA_WIDTH = 16,
  parameter int P_LEN_WIDTH  = 8,
  parameter int P_CNT_WIDTH  = 8,
  parameter int P_GAP_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [P_LEN_WIDTH-1:0]  cfg_len,
  input  logic [P_CNT_WIDTH-1:0]  cfg_num_pkts,
  input  logic [P_GAP_WIDTH-1:0]  cfg_gap,
  input  logic [P_DATA_WIDTH-1:0] cfg_seed,
  output logic                    busy,
  output logic                    done,
  output logic [P_CNT_WIDTH-1:0]  pkt_sent,
  output logic                    M_AXIS_T_VALID,
  input  logic                    M_AXIS_T_READY,
  output logic [P_DATA_WIDTH-1:0] M_AXIS_T_DATA,
  output logic                    M_AXIS_T_LAST
);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  state_t                  r_state, w_state;
  logic [P_DATA_WIDTH-1:0] r_data, w_data;
  logic [P_LEN_WIDTH-1:0]  r_beat, w_beat, r_len, w_len;
  logic [P_CNT_WIDTH-1:0]  r_pkt, w_pkt, r_num, w_num;
  logic [P_GAP_WIDTH-1:0]  r_gap, w_gap, r_gcnt, w_gcnt;
  logic                    r_valid, w_valid, r_last, w_last, r_done, w_done, r_busy;
  logic                    w_hs, w_final;
  assign w_hs    = r_valid & M_AXIS_T_READY;
  assign w_final = r_pkt == r_num - P_CNT_WIDTH'(1);
  always_comb begin
    w_state = r_state;
    w_data  = r_data;
    w_beat  = r_beat;
    w_len   = r_len;
    w_pkt   = r_pkt;
    w_num   = r_num;
    w_gap   = r_gap;
    w_gcnt  = r_gcnt;
    w_valid = r_valid;
    w_last  = r_last;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: if (start && cfg_len != '0 && cfg_num_pkts != '0) begin
        w_state = S_SEND;
        w_len   = cfg_len;
        w_num   = cfg_num_pkts;
        w_gap   = cfg_gap;
        w_data  = cfg_seed;
        w_beat  = '0;
        w_pkt   = '0;
        w_valid = 1'b1;
        w_last  = cfg_len == P_LEN_WIDTH'(1);
      end
      S_SEND: if (w_hs) begin
        w_data = r_data + P_DATA_WIDTH'(1);
        if (r_last) begin
          w_pkt  = r_pkt + P_CNT_WIDTH'(1);
          w_beat = '0;
          if (w_final) begin
            w_state = S_IDLE;
            w_valid = 1'b0;
            w_last  = 1'b0;
            w_done  = 1'b1;
          end else if (r_gap == '0) begin
            w_last = r_len == P_LEN_WIDTH'(1);
          end else begin
            w_state = S_GAP;
            w_gcnt  = r_gap;
            w_valid = 1'b0;
            w_last  = 1'b0;
          end
        end else begin
          w_beat = r_beat + P_LEN_WIDTH'(1);
          w_last = r_beat + P_LEN_WIDTH'(1) == r_len - P_LEN_WIDTH'(1);
        end
      end
      S_GAP: if (r_gcnt == P_GAP_WIDTH'(1)) begin
        w_state = S_SEND;
        w_valid = 1'b1;
        w_last  = r_len == P_LEN_WIDTH'(1);
      end else begin
        w_gcnt = r_gcnt - P_GAP_WIDTH'(1);
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_beat  <= '0;
      r_len   <= '0;
      r_pkt   <= '0;
      r_num   <= '0;
      r_gap   <= '0;
      r_gcnt  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_data  <= w_data;
      r_beat  <= w_beat;
      r_len   <= w_len;
      r_pkt   <= w_pkt;
      r_num   <= w_num;
      r_gap   <= w_gap;
      r_gcnt  <= w_gcnt;
      r_valid <= w_valid;
      r_last  <= w_last;
      r_done  <= w_done;
      r_busy  <= w_state != S_IDLE;
    end
  end
  assign busy           = r_busy;
  assign done           = r_done;
  assign pkt_sent       = r_pkt;
  assign M_AXIS_T_VALID = r_valid;
  assign M_AXIS_T_DATA  = r_data;
  assign M_AXIS_T_LAST  = r_last;
endmodule

// File: tb/tb_axis_pkt_source.sv
// tb_axis_pkt_source: directed and randomized bursts checked against a queue-based stream model
module tb_axis_pkt_source;
  logic        clk = 1'b0;
  logic        rst, start, ready;
  logic [7:0]  cfg_len, cfg_num_pkts;
  logic [3:0]  cfg_gap;
  logic [15:0] cfg_seed;
  logic        busy, done, valid, last;
  logic [7:0]  pkt_sent;
  logic [15:0] data;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {bit gap; logic [15:0] d; bit l;} item_t;
  item_t q[$];
  bit    rdy_pat[$];

  axis_pkt_source dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_num_pkts(cfg_num_pkts),
    .cfg_gap(cfg_gap), .cfg_seed(cfg_seed), .busy(busy), .done(done), .pkt_sent(pkt_sent),
    .M_AXIS_T_VALID(valid), .M_AXIS_T_READY(ready), .M_AXIS_T_DATA(data), .M_AXIS_T_LAST(last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [7:0] exp_pkt, input logic exp_done);
    chk({tag, "_valid"}, 32'(valid), 32'(0));
    chk({tag, "_last"}, 32'(last), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_pkt"}, 32'(pkt_sent), 32'(exp_pkt));
  endtask

  // Call at a negedge; returns at the negedge of the done cycle.
  task automatic run_burst(input string tag, input logic [15:0] seed, input int len, input int num,
                           input int gap, input int rmode, input bit interfere);
    logic [15:0] d = seed;
    int guard = 0;
    q.delete();
    for (int p = 0; p < num; p++) begin
      for (int b = 0; b < len; b++) begin
        q.push_back('{gap: 1'b0, d: d, l: (b == len - 1)});
        d++;
      end
      if (p < num - 1)
        for (int g = 0; g < gap; g++) q.push_back('{gap: 1'b1, d: 16'h0, l: 1'b0});
    end
    start = 1'b1;
    cfg_seed = seed;
    cfg_len = 8'(len);
    cfg_num_pkts = 8'(num);
    cfg_gap = 4'(gap);
    @(negedge clk);
    start = 1'b0;
    cfg_seed = 16'($urandom);
    cfg_len = 8'($urandom);
    cfg_num_pkts = 8'($urandom);
    cfg_gap = 4'($urandom);
    while (q.size() != 0 && guard < 5000) begin
      item_t it = q[0];
      guard++;
      start = 1'b0;
      chk({tag, "_valid"}, 32'(valid), 32'(!it.gap));
      chk({tag, "_busy"}, 32'(busy), 32'(1));
      chk({tag, "_done"}, 32'(done), 32'(0));
      if (!it.gap) begin
        chk({tag, "_data"}, 32'(data), 32'(it.d));
        chk({tag, "_last"}, 32'(last), 32'(it.l));
      end
      if (rdy_pat.size() != 0) ready = rdy_pat.pop_front();
      else ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 9) < 6);
      if (it.gap || ready) void'(q.pop_front());
      if (interfere && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        cfg_seed = 16'($urandom);
        cfg_len = 8'($urandom_range(1, 9));
        cfg_num_pkts = 8'($urandom_range(1, 9));
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (guard >= 5000) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_timeout observed=%0d expected=<5000 cycles", tag, guard);
    end
    check_idle({tag, "_end"}, 8'(num), 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    cfg_len = '0; cfg_num_pkts = '0; cfg_gap = '0; cfg_seed = '0;
    repeat (2) @(negedge clk);
    check_idle("reset", 8'h0, 1'b0);
    chk("reset_data", 32'(data), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    run_burst("basic", 16'h0010, 4, 1, 0, 0, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("pkt_hold", 32'(pkt_sent), 32'(1));
    rdy_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_burst("backpressure", 16'h0abc, 3, 1, 0, 0, 1'b0);
    run_burst("gaps", 16'h0000, 2, 3, 2, 0, 1'b0);
    run_burst("wrap", 16'hfffe, 1, 3, 0, 0, 1'b0);
    @(negedge clk);
    start = 1'b1; cfg_len = 8'd0; cfg_num_pkts = 8'd5; cfg_seed = 16'h5555;
    @(negedge clk);
    check_idle("ign_len0", 8'd3, 1'b0);
    cfg_len = 8'd5; cfg_num_pkts = 8'd0;
    @(negedge clk);
    check_idle("ign_num0", 8'd3, 1'b0);
    start = 1'b0;
    run_burst("midstart", 16'h2000, 4, 3, 1, 1, 1'b1);
    start = 1'b1; cfg_seed = 16'h1234; cfg_len = 8'd5; cfg_num_pkts = 8'd2; cfg_gap = 4'd1;
    @(negedge clk);
    start = 1'b0; ready = 1'b0;
    @(negedge clk);
    chk("stall_valid", 32'(valid), 32'(1));
    chk("stall_data", 32'(data), 32'(16'h1234));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst", 8'h0, 1'b0);
    chk("midrst_data", 32'(data), 32'(0));
    @(negedge clk);
    chk("midrst_nodone", 32'(done), 32'(0));
    run_burst("after_rst", 16'h4321, 3, 2, 1, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      run_burst("rand", 16'($urandom), $urandom_range(1, 6), $urandom_range(1, 4),
                $urandom_range(0, 3), 1, 1'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
